// File: rtl/bp_io_cmd_arbiter.sv
// rtl/bp_io_cmd_arbiter.sv - two-requester I/O command arbiter with credit/ID tracking; option BP_IO_ARB_LOADER_PRIORITY_EN
module bp_io_cmd_arbiter #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 512,
    parameter int max_credits_p  = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [1:0][header_width_p-1:0] req_header_i,
    input  logic [1:0][data_width_p-1:0]   req_data_i,
    input  logic [1:0]                     req_v_i,
    output logic [1:0]                     req_yumi_o,
    output logic [header_width_p-1:0]      io_cmd_header_o,
    output logic [data_width_p-1:0]        io_cmd_data_o,
    output logic                           io_cmd_v_o,
    input  logic                           io_cmd_yumi_i,
    input  logic [header_width_p-1:0]      io_resp_header_i,
    input  logic [data_width_p-1:0]        io_resp_data_i,
    input  logic                           io_resp_v_i,
    output logic                           io_resp_ready_o,
    output logic [header_width_p-1:0]      resp_header_o,
    output logic [data_width_p-1:0]        resp_data_o,
    output logic [1:0]                     resp_v_o,
    input  logic [1:0]                     resp_ready_i,
    output logic                           credits_empty_o,
    output logic                           err_o
);

    localparam int cnt_w = $clog2(max_credits_p + 1);
    localparam int ptr_w = (max_credits_p > 1) ? $clog2(max_credits_p) : 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(max_credits_p);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(max_credits_p - 1);

    logic [cnt_w-1:0]         count_r;
    logic [ptr_w-1:0]         rd_ptr_r;
    logic [ptr_w-1:0]         wr_ptr_r;
    logic [max_credits_p-1:0] id_r;
    logic                     last_r;
    logic                     err_r;

    logic grant;
    logic any_v;
    logic cmd_fire;
    logic empty;
    logic owner;
    logic resp_fire;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + ptr_w'(1);
    endfunction

    // Grant selection: round-robin on last_r, or fixed loader priority when enabled.
    always_comb begin
        grant = 1'b0;
`ifdef BP_IO_ARB_LOADER_PRIORITY_EN
        grant = req_v_i[0] ? 1'b0 : (req_v_i[1] ? 1'b1 : last_r);
`else
        if (req_v_i == 2'b11) begin
            grant = ~last_r;
        end else begin
            grant = req_v_i[1];
        end
`endif
    end

    // Command path: zero-latency mux, gated by credits and held quiet during reset.
    always_comb begin
        any_v           = |req_v_i;
        io_cmd_v_o      = reset_n_i & any_v & (count_r < full_cnt);
        io_cmd_header_o = any_v ? req_header_i[grant] : '0;
        io_cmd_data_o   = any_v ? req_data_i[grant] : '0;
        cmd_fire        = io_cmd_v_o & io_cmd_yumi_i;
        req_yumi_o      = cmd_fire ? (2'b01 << grant) : 2'b00;
    end

    // Response path: route to the owner at the ID FIFO head; drop responses with nothing outstanding.
    always_comb begin
        empty           = (count_r == '0);
        owner           = id_r[rd_ptr_r];
        resp_header_o   = io_resp_header_i;
        resp_data_o     = io_resp_data_i;
        resp_v_o        = (io_resp_v_i & ~empty) ? (2'b01 << owner) : 2'b00;
        io_resp_ready_o = empty | resp_ready_i[owner];
        resp_fire       = io_resp_v_i & io_resp_ready_o & ~empty;
        credits_empty_o = empty;
        err_o           = err_r;
    end

    // Credit count, FIFO pointers, round-robin pointer and sticky error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            last_r   <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
                last_r   <= grant;
            end
            if (resp_fire) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({cmd_fire, resp_fire})
                2'b10:   count_r <= count_r + cnt_w'(1);
                2'b01:   count_r <= count_r - cnt_w'(1);
                default: count_r <= count_r;
            endcase
            if (io_resp_v_i && empty) begin
                err_r <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (cmd_fire) begin
            id_r[wr_ptr_r] <= grant;
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb/tb_bp_io_cmd_arbiter.sv - self-checking bench for bp_io_cmd_arbiter with a queue-based reference model
module tb_bp_io_cmd_arbiter;

    localparam int HW = 64;
    localparam int DW = 512;
    localparam int MC = 16;

    logic                 clk_i = 1'b0;
    logic                 reset_n_i;
    logic [1:0][HW-1:0]   req_header_i;
    logic [1:0][DW-1:0]   req_data_i;
    logic [1:0]           req_v_i;
    logic [1:0]           req_yumi_o;
    logic [HW-1:0]        io_cmd_header_o;
    logic [DW-1:0]        io_cmd_data_o;
    logic                 io_cmd_v_o;
    logic                 io_cmd_yumi_i;
    logic [HW-1:0]        io_resp_header_i;
    logic [DW-1:0]        io_resp_data_i;
    logic                 io_resp_v_i;
    logic                 io_resp_ready_o;
    logic [HW-1:0]        resp_header_o;
    logic [DW-1:0]        resp_data_o;
    logic [1:0]           resp_v_o;
    logic [1:0]           resp_ready_i;
    logic                 credits_empty_o;
    logic                 err_o;

    int checks = 0;
    int errors = 0;

    // reference model: queue of owning requesters, last served requester, sticky error
    bit   mq[$];
    bit   m_last;
    bit   m_err;

    logic       e_cmd_v;
    logic [1:0] e_yumi;
    logic       e_grant;
    logic [1:0] e_resp_v;
    logic       e_ready;
    logic       e_empty;

    bp_io_cmd_arbiter #(.header_width_p(HW), .data_width_p(DW), .max_credits_p(MC)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_header_i(req_header_i), .req_data_i(req_data_i),
        .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
        .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o),
        .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_header_i(io_resp_header_i), .io_resp_data_i(io_resp_data_i),
        .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
        .resp_header_o(resp_header_o), .resp_data_o(resp_data_o),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .credits_empty_o(credits_empty_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_eval();
`ifdef BP_IO_ARB_LOADER_PRIORITY_EN
        e_grant = !req_v_i[0] && req_v_i[1];
`else
        if (req_v_i == 2'b11) e_grant = !m_last;
        else                  e_grant = req_v_i[1];
`endif
        e_cmd_v = (req_v_i != 2'b00) && (mq.size() < MC);
        e_yumi  = (e_cmd_v && io_cmd_yumi_i) ? (e_grant ? 2'b10 : 2'b01) : 2'b00;
        e_empty = (mq.size() == 0);
        if (!e_empty) begin
            e_resp_v = io_resp_v_i ? (mq[0] ? 2'b10 : 2'b01) : 2'b00;
            e_ready  = resp_ready_i[mq[0]];
        end else begin
            e_resp_v = 2'b00;
            e_ready  = 1'b1;
        end
    endtask

    task automatic model_commit();
        bit popped;
        popped = io_resp_v_i && !e_empty && e_ready;
        if (io_resp_v_i && e_empty) m_err = 1'b1;
        if (popped) void'(mq.pop_front());
        if (e_yumi != 2'b00) begin
            mq.push_back(e_grant);
            m_last = e_grant;
        end
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_v_i       = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b0;
        resp_ready_i  = 2'b11;
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 1'b0;
        mq.delete();
        m_last = 1'b1;
        m_err  = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        #1;
    endtask

    task automatic drain();
        int n;
        req_v_i       = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b1;
        resp_ready_i  = 2'b11;
        n = mq.size();
        for (int i = 0; i < n; i++) tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        reset_n_i        = 1'b0;
        req_v_i          = 2'b11;
        io_cmd_yumi_i    = 1'b1;
        io_resp_v_i      = 1'b1;
        resp_ready_i     = 2'b00;
        req_header_i     = '0;
        req_data_i       = '0;
        io_resp_header_i = '0;
        io_resp_data_i   = '0;
        #3;
        checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_v got %b exp 0", io_cmd_v_o); end
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi got %b exp 00", req_yumi_o); end
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL reset_resp_v got %b exp 00", resp_v_o); end
        checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", io_resp_ready_o); end
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", credits_empty_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        do_reset();
    endtask

    task automatic test_single();
        logic [HW-1:0] h;
        do_reset();
        h = {$urandom, $urandom};
        req_header_i[0] = h;
        req_v_i         = 2'b01;
        io_cmd_yumi_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL single_yumi[%0d] got %b exp 01", i, req_yumi_o); end
            checks++; if (io_cmd_header_o !== h) begin errors++; $display("FAIL single_hdr[%0d] got %h exp %h", i, io_cmd_header_o, h); end
            tick();
        end
        req_v_i       = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b1;
        io_resp_header_i = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (resp_v_o !== 2'b01) begin errors++; $display("FAIL single_resp_v[%0d] got %b exp 01", i, resp_v_o); end
            checks++; if (credits_empty_o !== 1'b0) begin errors++; $display("FAIL single_nonempty[%0d] got %b exp 0", i, credits_empty_o); end
            checks++; if (resp_header_o !== io_resp_header_i) begin errors++; $display("FAIL single_resp_hdr got %h exp %h", resp_header_o, io_resp_header_i); end
            tick();
        end
        io_resp_v_i = 1'b0;
        #1;
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL single_empty_end got %b exp 1", credits_empty_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4];
`ifdef BP_IO_ARB_LOADER_PRIORITY_EN
        seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b01;
`else
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
`endif
        do_reset();
        req_v_i       = 2'b11;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_yumi_o !== seq[i]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_yumi_o, seq[i]); end
            tick();
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        req_v_i       = 2'b01;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < MC; i++) tick();
        #1;
        checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL full_cmd_v got %b exp 0", io_cmd_v_o); end
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL full_yumi got %b exp 00", req_yumi_o); end
        io_resp_v_i = 1'b1;
        #1;
        checks++; if (resp_v_o !== 2'b01) begin errors++; $display("FAIL full_pop_resp got %b exp 01", resp_v_o); end
        checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_cmd_v got %b exp 0", io_cmd_v_o); end
        tick();
        io_resp_v_i   = 1'b0;
        io_cmd_yumi_i = 1'b0;
        #1;
        checks++; if (io_cmd_v_o !== 1'b1) begin errors++; $display("FAIL full_reopen got %b exp 1", io_cmd_v_o); end
        drain();
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", credits_empty_o); end
    endtask

    task automatic test_interleave();
        bit         ids [4];
        logic [1:0] exp_v [4];
        ids[0] = 0; ids[1] = 1; ids[2] = 1; ids[3] = 0;
        exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b10; exp_v[3] = 2'b01;
        do_reset();
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_v_i = ids[i] ? 2'b10 : 2'b01;
            tick();
        end
        req_v_i       = 2'b00;
        io_cmd_yumi_i = 1'b0;
        io_resp_v_i   = 1'b1;
        resp_ready_i  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (resp_v_o !== exp_v[i]) begin errors++; $display("FAIL il_resp_v[%0d] got %b exp %b", i, resp_v_o, exp_v[i]); end
            if (i == 1) begin
                for (int k = 0; k < 2; k++) begin
                    checks++; if (io_resp_ready_o !== 1'b0) begin errors++; $display("FAIL il_stall_ready[%0d] got %b exp 0", k, io_resp_ready_o); end
                    tick();
                    #1;
                    checks++; if (resp_v_o !== 2'b10) begin errors++; $display("FAIL il_stall_hold[%0d] got %b exp 10", k, resp_v_o); end
                end
                resp_ready_i = 2'b11;
                #1;
            end
            checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL il_ready[%0d] got %b exp 1", i, io_resp_ready_o); end
            tick();
        end
        io_resp_v_i = 1'b0;
        #1;
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL il_empty got %b exp 1", credits_empty_o); end
    endtask

    task automatic test_error();
        do_reset();
        io_resp_v_i  = 1'b1;
        resp_ready_i = 2'b00;
        #1;
        checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL err_ready got %b exp 1", io_resp_ready_o); end
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL err_resp_v got %b exp 00", resp_v_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err_o); end
        tick();
        idle();
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_o); end
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL err_count got %b exp 1", credits_empty_o); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
        do_reset();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err_o); end
    endtask

    task automatic test_random();
        logic [1:0] y;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_v_i[r] && ($urandom_range(2) == 0)) begin
                    req_v_i[r]      = 1'b1;
                    req_header_i[r] = {$urandom, $urandom};
                    req_data_i[r]   = {16{$urandom}};
                end
            end
            model_eval();
            io_cmd_yumi_i = e_cmd_v && ($urandom_range(3) != 0);
            io_resp_v_i   = e_empty ? ($urandom_range(15) == 0) : ($urandom_range(2) != 0);
            resp_ready_i  = 2'($urandom_range(3));
            io_resp_header_i = {$urandom, $urandom};
            #1;
            model_eval();
            checks++; if (io_cmd_v_o !== e_cmd_v) begin errors++; $display("FAIL rnd_cmd_v c=%0d got %b exp %b", c, io_cmd_v_o, e_cmd_v); end
            checks++; if (req_yumi_o !== e_yumi) begin errors++; $display("FAIL rnd_yumi c=%0d got %b exp %b", c, req_yumi_o, e_yumi); end
            if (e_cmd_v) begin
                checks++; if (io_cmd_header_o !== req_header_i[e_grant]) begin errors++; $display("FAIL rnd_hdr c=%0d got %h exp %h", c, io_cmd_header_o, req_header_i[e_grant]); end
                checks++; if (io_cmd_data_o !== req_data_i[e_grant]) begin errors++; $display("FAIL rnd_data c=%0d mismatch on requester %0d", c, e_grant); end
            end
            checks++; if (resp_v_o !== e_resp_v) begin errors++; $display("FAIL rnd_resp_v c=%0d got %b exp %b", c, resp_v_o, e_resp_v); end
            checks++; if (io_resp_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, io_resp_ready_o, e_ready); end
            checks++; if (credits_empty_o !== e_empty) begin errors++; $display("FAIL rnd_empty c=%0d got %b exp %b", c, credits_empty_o, e_empty); end
            checks++; if (err_o !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, err_o, m_err); end
            y = e_yumi;
            tick();
            req_v_i = req_v_i & ~y;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_v_i       = 2'b01;
        io_cmd_yumi_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        req_v_i = 2'b11;
        #1;
        checks++; if (credits_empty_o !== 1'b0) begin errors++; $display("FAIL mid_outstanding got %b exp 0", credits_empty_o); end
        io_resp_v_i = 1'b1;
        #1;
        reset_n_i = 1'b0;
        mq.delete();
        m_last = 1'b1;
        m_err  = 1'b0;
        #1;
        checks++; if (io_cmd_v_o !== 1'b0) begin errors++; $display("FAIL mid_cmd_v got %b exp 0", io_cmd_v_o); end
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL mid_yumi got %b exp 00", req_yumi_o); end
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL mid_resp_v got %b exp 00", resp_v_o); end
        checks++; if (io_resp_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", io_resp_ready_o); end
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", credits_empty_o); end
        io_resp_v_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        #1;
        checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL mid_first_grant got %b exp 01", req_yumi_o); end
        checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL mid_count0 got %b exp 1", credits_empty_o); end
        tick();
        req_v_i       = 2'b00;
        io_cmd_yumi_i = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_interleave();
        test_error();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_io_cmd_arbiter.md
# bp_io_cmd_arbiter

Two-requester arbiter that shares one BedRock I/O command/response channel between the stream NBF loader (requester 0) and a host debug/MMIO bridge (requester 1). It grants the command channel round-robin, enforces the channel's outstanding-credit limit, and records the issuing requester of every accepted command. In-order responses are routed back to the requester that issued the matching command. It sits between the requesters and the I/O NoC link of the FPGA host interface.

## Interface
- header_width_p, 64: width of a BedRock mem header (mem_header_width_lp at instantiation)
- data_width_p, 512: command/response data width (cce_block_width_p)
- max_credits_p, 16: maximum outstanding commands (io_noc_max_credits_p); ≥1
- clk_i  in  1  sole clock; all state on rising edge
- reset_n_i  in  1  reset, asynchronous assert, active-low; all state cleared while low
- req_header_i  in  2×header_width_p  per-requester command header
- req_data_i  in  2×data_width_p  per-requester command data
- req_v_i  in  2  per-requester command valid
- req_yumi_o  out  2  per-requester command consumed
- io_cmd_header_o  out  header_width_p  granted header
- io_cmd_data_o  out  data_width_p  granted data
- io_cmd_v_o  out  1  command valid to link
- io_cmd_yumi_i  in  1  link consumed command
- io_resp_header_i  in  header_width_p  response header
- io_resp_data_i  in  data_width_p  response data
- io_resp_v_i  in  1  response valid
- io_resp_ready_o  out  1  response accepted when high with io_resp_v_i
- resp_header_o  out  header_width_p  response header broadcast to both requesters
- resp_data_o  out  data_width_p  response data broadcast
- resp_v_o  out  2  response valid, one-hot by owning requester
- resp_ready_i  in  2  per-requester response ready
- credits_empty_o  out  1  no commands outstanding
- err_o  out  1  sticky: response received with nothing outstanding

## Operation
- Credit/ID tracker: FIFO of 1-bit requester IDs, depth max_credits_p; occupancy is the credit count (width `BSG_WIDTH(max_credits_p)`).
- Grant: among requesters with req_v_i high, select by round-robin pointer `last_r` (the requester not last served wins; with one requester valid, that one wins). The grant is combinational and carries no state other than `last_r`.
- io_cmd_v_o = (|req_v_i) & (count < max_credits_p). Header/data mux from the granted requester; they are '0 when no requester is valid.
- req_yumi_o[g] = io_cmd_yumi_i for the granted g only. On yumi: push g into the ID FIFO and set `last_r <= g`.
- Response: owner = FIFO head. resp_v_o[owner] = io_resp_v_i & ~empty. io_resp_ready_o = empty | resp_ready_i[owner]. On io_resp_v_i & io_resp_ready_o & ~empty, pop.
- io_resp_v_i while empty: the response is accepted and dropped, err_o is set, and the count is unchanged.
- Simultaneous push and pop: the count is unchanged and the FIFO advances both pointers. At count==max_credits_p, io_cmd_v_o is low, so no push coincides with full. A pop at full reopens issue the next cycle.
- Pointer wrap: FIFO pointers wrap modulo max_credits_p. Non-power-of-two depths wrap explicitly at max_credits_p-1.
- Reset (any time, including mid-transaction): FIFO is emptied, count=0, `last_r`=1 (requester 0 wins first tie), err_o=0. Outstanding transactions are forgotten.

## Timing
- Command path is zero-latency combinational (req → io_cmd). The response path is zero-latency combinational (io_resp → resp). No registered data.
- Credit state updates on the edge after the handshake. A command accepted in cycle N is visible in the count in cycle N+1.
- A response may pop in the same cycle its command is pushed only if the FIFO was already non-empty, because the head is the older entry.
- Reset values: io_cmd_v_o=0, req_yumi_o=0, resp_v_o=0, io_resp_ready_o=1, credits_empty_o=1, err_o=0. These values hold asynchronously while reset_n_i is low.
- The link must not drop io_cmd_v_o-qualified data mid-handshake. Requesters must hold req_v_i/header/data until yumi.

## Configuration
- BP_IO_ARB_LOADER_PRIORITY_EN:
  - Defined: requester 0 (loader) has fixed priority and wins whenever req_v_i[0] is high. `last_r` is still maintained but ignored.
  - Undefined: round-robin as above.

## Test plan
- Single requester 0 issues 3 commands, the link yumis each immediately, and 3 responses return. Required: resp_v_o=2'b01 ×3, count 0→3→0, credits_empty_o high at end.
- Both requesters valid continuously with round-robin. Required: grants alternate 0,1,0,1; the first grant goes to 0 after reset. With BP_IO_ARB_LOADER_PRIORITY_EN, all grants go to 0.
- Issue max_credits_p=16 commands with no responses. Required: io_cmd_v_o low at count 16. A response in the same cycle pops and io_cmd_v_o rises the next cycle.
- Interleave issues 0,1,1,0 with in-order responses. Required: resp_v_o sequence 01,10,10,01. With resp_ready_i[1] low, io_resp_ready_o low until it rises.
- Response with count 0. Required: io_resp_ready_o=1, err_o sets and stays high until reset, and no resp_v_o.
- Assert reset_n_i low with 5 outstanding. Required: outputs take reset values immediately (asynchronously), count=0, and grant priority returns to requester 0.
